bit_sync_filt: RTL and testbench

- Multi-channel bit synchronizer: each of BUS_WIDTH independent asynchronous inputs goes through a NUM_STAGES flip-flop chain into CLK.
- Each channel then passes a stability (glitch) filter and an edge detector.
- Provides a filtered level, one-cycle rise/fall pulses and a per-channel change flag.
- Sits at clock-domain and pad boundaries (buttons, status lines, slow control bits); replaces plain per-bit synchronizer chains where debouncing or edge events are needed.

---
 rtl/bit_sync_filt.sv | 90 +++++++++
 tb/tb_bit_sync_filt.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bit_sync_filt.sv
// Multi-channel bit synchronizer with per-channel stability filter and registered edge pulses.
// Define BIT_SYNC_STICKY_EN to add CLR_STICKY/STICKY per-channel sticky change flags.
module bit_sync_filt #(
  parameter int                   BUS_WIDTH   = 4,
  parameter int                   NUM_STAGES  = 2,
  parameter int                   FILT_CYCLES = 1,
  parameter logic [BUS_WIDTH-1:0] RST_VAL     = {BUS_WIDTH{1'b0}}
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] ASYNC,
`ifdef BIT_SYNC_STICKY_EN
  input  logic [BUS_WIDTH-1:0] CLR_STICKY,
  output logic [BUS_WIDTH-1:0] STICKY,
`endif
  output logic [BUS_WIDTH-1:0] SYNC,
  output logic [BUS_WIDTH-1:0] RISE,
  output logic [BUS_WIDTH-1:0] FALL,
  output logic [BUS_WIDTH-1:0] CHG
);

  localparam int               CNT_W   = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_CYCLES - 1);

  logic [BUS_WIDTH-1:0] stage_q [NUM_STAGES];
  logic [BUS_WIDTH-1:0] s;
  logic [CNT_W-1:0]     cnt_q   [BUS_WIDTH];
  logic [CNT_W-1:0]     cnt_d   [BUS_WIDTH];
  logic [BUS_WIDTH-1:0] sync_q, sync_d;
  logic [BUS_WIDTH-1:0] rise_q, fall_q, chg_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int k = 0; k < NUM_STAGES; k++) stage_q[k] <= RST_VAL;
    end else begin
      stage_q[0] <= ASYNC;
      for (int k = 1; k < NUM_STAGES; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  assign s = stage_q[NUM_STAGES-1];

  // Counter tracks consecutive samples disagreeing with SYNC; any agreeing sample restarts it.
  always_comb begin
    sync_d = sync_q;
    for (int i = 0; i < BUS_WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s[i] != sync_q[i]) begin
        if (cnt_q[i] == CNT_MAX) sync_d[i] = s[i];
        else                     cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q <= RST_VAL;
      cnt_q  <= '{default: '0};
      rise_q <= '0;
      fall_q <= '0;
      chg_q  <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      rise_q <= sync_d & ~sync_q;
      fall_q <= ~sync_d & sync_q;
      chg_q  <= sync_d ^ sync_q;
    end
  end

  assign SYNC = sync_q;
  assign RISE = rise_q;
  assign FALL = fall_q;
  assign CHG  = chg_q;

`ifdef BIT_SYNC_STICKY_EN
  logic [BUS_WIDTH-1:0] sticky_q, sticky_d;

  // A change event overrides a clear arriving in the same cycle.
  assign sticky_d = chg_q | (sticky_q & ~CLR_STICKY);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) sticky_q <= '0;
    else      sticky_q <= sticky_d;
  end

  assign STICKY = sticky_q;
`endif

endmodule

// File: tb/tb_bit_sync_filt.sv
// Randomized and directed bench for bit_sync_filt against a window-based reference model.
module tb_bit_sync_filt;
  localparam int            BW = 4;
  localparam int            NS = 2;
  localparam int            FC = 3;
  localparam logic [BW-1:0] RV = '0;

  logic          CLK   = 1'b0;
  logic          RST   = 1'b0;
  logic [BW-1:0] ASYNC = '0;
  logic [BW-1:0] SYNC, RISE, FALL, CHG;
`ifdef BIT_SYNC_STICKY_EN
  logic [BW-1:0] CLR_STICKY = '0;
  logic [BW-1:0] STICKY;
`endif

  bit_sync_filt #(
    .BUS_WIDTH(BW), .NUM_STAGES(NS), .FILT_CYCLES(FC), .RST_VAL(RV)
  ) dut (
    .CLK(CLK), .RST(RST), .ASYNC(ASYNC),
`ifdef BIT_SYNC_STICKY_EN
    .CLR_STICKY(CLR_STICKY), .STICKY(STICKY),
`endif
    .SYNC(SYNC), .RISE(RISE), .FALL(FALL), .CHG(CHG)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", tag, $time, obs, exp);
    end
  endtask

  // Reference: a sample delay line of NS cycles feeds the filter; a channel flips
  // when the last FC samples seen by the filter all disagree with the current level.
  logic [BW-1:0] dly[$];
  logic [BW-1:0] win[$];
  logic [BW-1:0] m_sync = RV, m_rise = '0, m_fall = '0, m_chg = '0, m_sticky = '0;

  always @(posedge CLK or negedge RST) begin
    logic [BW-1:0] s_now, nxt;
    bit            all_diff;
    if (!RST) begin
      dly.delete();
      for (int k = 0; k < NS; k++) dly.push_back(RV);
      win.delete();
      m_sync = RV; m_rise = '0; m_fall = '0; m_chg = '0; m_sticky = '0;
    end else begin
      s_now = dly.pop_front();
      dly.push_back(ASYNC);
      win.push_back(s_now);
      if (win.size() > FC) void'(win.pop_front());
      nxt = m_sync;
      for (int i = 0; i < BW; i++) begin
        all_diff = (win.size() == FC);
        foreach (win[k]) if (win[k][i] == m_sync[i]) all_diff = 0;
        if (all_diff) nxt[i] = ~m_sync[i];
      end
`ifdef BIT_SYNC_STICKY_EN
      m_sticky = m_chg | (m_sticky & ~CLR_STICKY);
`endif
      m_rise = nxt & ~m_sync;
      m_fall = ~nxt & m_sync;
      m_chg  = m_rise | m_fall;
      m_sync = nxt;
    end
  end

  task automatic tick(input string tag);
    @(posedge CLK);
    #1;
    chk({tag, ".sync"}, SYNC, m_sync);
    chk({tag, ".rise"}, RISE, m_rise);
    chk({tag, ".fall"}, FALL, m_fall);
    chk({tag, ".chg"},  CHG,  m_chg);
`ifdef BIT_SYNC_STICKY_EN
    chk({tag, ".sticky"}, STICKY, m_sticky);
`endif
  endtask

  task automatic pulse_reset(input string tag);
    RST = 1'b0;
    #1;
    chk({tag, ".rst_sync"}, SYNC, RV);
    chk({tag, ".rst_chg"},  CHG,  '0);
    #2;
    RST = 1'b1;
  endtask

  task automatic wait_chg(input int ch, input string tag);
    bit seen = 0;
    for (int n = 0; n < 12 && !seen; n++) begin
      tick(tag);
      if (CHG[ch]) seen = 1;
    end
    if (!seen) chk({tag, ".timeout"}, 32'd0, 32'd1);
  endtask

  logic [BW-1:0] acc;
  int            cnt_r, cnt_f;

  initial begin
    // Reset held with all inputs high: nothing may leak through.
    ASYNC = 4'hF;
    for (int n = 0; n < 3; n++) tick("rst_hold");
    chk("rst_hold.sync0", SYNC, 4'h0);
    RST = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick("first");
      if (e < 5) begin
        chk("first.sync_early", SYNC, 4'h0);
        chk("first.rise_early", RISE, 4'h0);
      end else if (e == 5) begin
        chk("first.sync_e5", SYNC, 4'hF);
        chk("first.rise_e5", RISE, 4'hF);
        chk("first.chg_e5",  CHG,  4'hF);
      end else begin
        chk("first.rise_e6", RISE, 4'h0);
      end
    end

    ASYNC = 4'h0;
    for (int n = 0; n < 8; n++) tick("settle0");

    // Two-cycle glitch on channel 0 must be swallowed.
    ASYNC[0] = 1'b1;
    tick("glitch");
    tick("glitch");
    ASYNC[0] = 1'b0;
    for (int n = 0; n < 8; n++) begin
      tick("glitch");
      chk("glitch.chg0", CHG[0], 1'b0);
    end

    // Channel 1 step up then down: exactly one rise and one fall pulse.
    cnt_r = 0; cnt_f = 0;
    ASYNC[1] = 1'b1;
    for (int n = 0; n < 8; n++) begin tick("ch1"); cnt_r += RISE[1]; end
    ASYNC[1] = 1'b0;
    for (int n = 0; n < 8; n++) begin tick("ch1"); cnt_f += FALL[1]; end
    chk("ch1.nrise", cnt_r, 1);
    chk("ch1.nfall", cnt_f, 1);

    // Simultaneous step on channels 0 and 2.
    acc = '0; cnt_r = 0;
    ASYNC = 4'b0101;
    for (int n = 0; n < 8; n++) begin
      tick("multi");
      acc |= RISE;
      if (RISE != 0) cnt_r++;
    end
    chk("multi.rise_or", acc, 4'b0101);
    chk("multi.rise_cycles", cnt_r, 1);

    ASYNC = 4'h0;
    for (int n = 0; n < 8; n++) tick("settle1");

    // Reset while channel 2 is mid-count; full latency restarts afterwards.
    ASYNC = 4'b0100;
    for (int n = 0; n < 3; n++) tick("midrst");
    pulse_reset("midrst");
    for (int e = 1; e <= 5; e++) begin
      tick("midrst");
      if (e < 5) chk("midrst.sync2_early", SYNC[2], 1'b0);
      else       chk("midrst.sync2_e5", SYNC[2], 1'b1);
    end

    ASYNC = 4'h0;
    for (int n = 0; n < 8; n++) tick("settle2");

`ifdef BIT_SYNC_STICKY_EN
    CLR_STICKY = 4'hF;
    tick("stk");
    CLR_STICKY = 4'h0;
    ASYNC[3] = 1'b1;
    wait_chg(3, "stk_rise");
    tick("stk");
    chk("stk.set", STICKY[3], 1'b1);
    ASYNC[3] = 1'b0;
    wait_chg(3, "stk_fall");
    CLR_STICKY[3] = 1'b1;
    tick("stk");
    chk("stk.set_wins", STICKY[3], 1'b1);
    tick("stk");
    chk("stk.cleared", STICKY[3], 1'b0);
    CLR_STICKY = 4'h0;
`endif

    // Random phase: decreasing toggle rates give glitches and settled steps alike.
    for (int p = 0; p < 3; p++) begin
      for (int n = 0; n < 300; n++) begin
        for (int i = 0; i < BW; i++)
          if ($urandom_range(0, (1 << (p + 1)) - 1) == 0) ASYNC[i] = ~ASYNC[i];
`ifdef BIT_SYNC_STICKY_EN
        CLR_STICKY = ($urandom_range(0, 3) == 0) ? BW'($urandom) : '0;
`endif
        if ($urandom_range(0, 149) == 0) pulse_reset("rnd");
        tick("rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
